select_issue: RTL and testbench
===============================

Name: select_issue

Overview:
- Consumer side of the wakeup entry tracker's request/grant/retire interface, one instance per FU pipe.
- Accepts the per-entry request vector and grants the oldest requesting entry using an age matrix.
- Holds the granted entry in an issue register until the functional unit accepts it.
- Tracks FU latency, then broadcasts the wakeup `ready_mask` bit and the retire strobe back to the tracker.

Parameters:
RS_ENTRIES, 8, reservation-station entries (power of 2, >=2)
NUM_FUS, 4, FU pipes sharing the ready_mask bus
FU_ID, 0, this pipe's index, 0..NUM_FUS-1
FU_LATENCY, 3, cycles from FU handoff to result broadcast (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
disp_valid  in  1  entry allocated this cycle (age update)
disp_entry  in  $clog2(RS_ENTRIES)  index allocated (tracker free_entry_out)
reqs  in  RS_ENTRIES  ready-and-ungranted entries from tracker
grant  out  $clog2(RS_ENTRIES)  selected entry
grant_valid  out  1  grant qualifier
issue_valid  out  1  issue register holds an entry for the FU
issue_entry  out  $clog2(RS_ENTRIES)  entry presented to FU
fu_ready  in  1  FU accepts issue this cycle
ready_mask  out  RS_ENTRIES*NUM_FUS  completion broadcast; bit FU_ID*RS_ENTRIES+e
retire_entry  out  $clog2(RS_ENTRIES)  entry to free
retire_valid  out  1  retire qualifier

Behaviour:
- Internal state:
  - `alloc[RS_ENTRIES]`: allocated flags.
  - `older[i][j]`: 1 means entry j is older than entry i.
  - Issue register.
  - FU_LATENCY-deep pipeline of {valid, entry}.
- Reset: all state cleared. Outputs after reset: grant_valid=0, grant=0, issue_valid=0, issue_entry=0, ready_mask=0, retire_valid=0, retire_entry=0. In-flight ops are discarded.
- Dispatch (disp_valid):
  - alloc[disp_entry]<=1.
  - older[disp_entry][j]<=alloc[j] for all j != disp_entry, using the pre-update alloc.
  - older[j][disp_entry]<=0 for all j.
- Retire (retire_valid): alloc[retire_entry]<=0 and column older[*][retire_entry]<=0.
- disp_entry==retire_entry in the same cycle is illegal. The tracker never offers a valid entry as free; the bench asserts this.
- Select is combinational, same cycle as reqs:
  - can_issue = !issue_valid | fu_ready.
  - Candidate i satisfies reqs[i] & ((older[i] & reqs)==0).
  - Exactly one candidate exists when reqs!=0; the lowest index breaks ties defensively.
  - grant_valid = (reqs!=0) & can_issue. grant = candidate index, else 0.
- Issue register:
  - If grant_valid: issue_valid<=1, issue_entry<=grant. This may replace an entry being handed off in the same cycle.
  - Else if fu_ready: issue_valid<=0.
  - While issue_valid & !fu_ready, issue_entry is held stable and no grant is made.
- Handoff: issue_valid & fu_ready at cycle T pushes {1, issue_entry} into pipeline stage 0.
- Completion at cycle T+FU_LATENCY, for exactly one cycle, from registered outputs:
  - retire_valid=1, retire_entry=e.
  - ready_mask = one-hot at FU_ID*RS_ENTRIES+e; all other bits 0.
- Otherwise ready_mask=0, retire_valid=0, retire_entry=0.
- Throughput: one issue per cycle when fu_ready stays high. The pipeline never stalls.
- Reset asserted mid-operation clears the pipeline; no retire or ready pulse is emitted afterward.

Test Plan:
1. Reset, then reqs=8'hFF -> grant_valid=1, grant=0 in the same cycle.
2. Dispatch entries 5, 2, 7 in consecutive cycles, then reqs=8'b1010_0100 -> grant=5. Next, with reqs=8'b1000_0100 -> grant=2.
3. Grant entry 3 with fu_ready=0 for 4 cycles -> issue_valid=1, issue_entry=3 held, grant_valid=0 despite reqs=8'h01. Then fu_ready=1 -> grant=0 in that same cycle.
4. FU_ID=1, FU_LATENCY=3: handoff of entry 4 at cycle 10 -> cycle 13: ready_mask bit 12 set only, retire_valid=1, retire_entry=4. Cycle 14: ready_mask=0.
5. Back-to-back: reqs continuous over 3 entries with fu_ready=1 -> three consecutive retire pulses, oldest first, no bubbles.
6. Assert rst two cycles after handoff -> no retire_valid or ready_mask pulse afterward; the age state is cleared so the next grant uses lowest index.

Source files
------------

// File: rtl/select_issue.sv
// Age-matrix select and issue stage for one FU pipe: grants the oldest requesting
// entry, holds it until the FU accepts it, then retires it after a fixed latency.
module select_issue #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_FUS    = 4,
    parameter int FU_ID      = 0,
    parameter int FU_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_valid,
    input  logic [$clog2(RS_ENTRIES)-1:0] disp_entry,
    input  logic [RS_ENTRIES-1:0]         reqs,
    output logic [$clog2(RS_ENTRIES)-1:0] grant,
    output logic                          grant_valid,
    output logic                          issue_valid,
    output logic [$clog2(RS_ENTRIES)-1:0] issue_entry,
    input  logic                          fu_ready,
    output logic [RS_ENTRIES*NUM_FUS-1:0] ready_mask,
    output logic [$clog2(RS_ENTRIES)-1:0] retire_entry,
    output logic                          retire_valid
);
    localparam int IW        = $clog2(RS_ENTRIES);
    localparam int MW        = RS_ENTRIES * NUM_FUS;
    localparam int MASK_BASE = FU_ID * RS_ENTRIES;

    logic [RS_ENTRIES-1:0] alloc_q, alloc_d;
    logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] older_d [RS_ENTRIES];

    logic          issue_valid_q;
    logic [IW-1:0] issue_entry_q;

    logic          pipe_v_q [FU_LATENCY];
    logic [IW-1:0] pipe_e_q [FU_LATENCY];
    logic          pipe_v_d [FU_LATENCY];
    logic [IW-1:0] pipe_e_d [FU_LATENCY];
    logic [MW-1:0] ready_mask_q, ready_mask_d;

    logic          can_issue;
    logic          handoff;
    logic          found;
    logic [IW-1:0] cand;

    assign can_issue = !issue_valid_q || fu_ready;
    assign handoff   = issue_valid_q && fu_ready;

    // A requester wins when no other requester is older; lowest index only matters if the matrix is ever inconsistent.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!found && reqs[i] && ((older_q[i] & reqs) == '0)) begin
                found = 1'b1;
                cand  = IW'(i);
            end
        end
    end

    assign grant       = cand;
    assign grant_valid = (|reqs) && can_issue;

    // Retire clears its column last so a same-cycle dispatch never records the departing entry as older.
    always_comb begin
        alloc_d = alloc_q;
        older_d = older_q;
        if (disp_valid) begin
            alloc_d[disp_entry] = 1'b1;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                older_d[disp_entry][j] = alloc_q[j] && (IW'(j) != disp_entry);
                older_d[j][disp_entry] = 1'b0;
            end
        end
        if (retire_valid) begin
            alloc_d[retire_entry] = 1'b0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                older_d[i][retire_entry] = 1'b0;
            end
        end
    end

    always_comb begin
        pipe_v_d[0] = handoff;
        pipe_e_d[0] = handoff ? issue_entry_q : '0;
        for (int k = 1; k < FU_LATENCY; k++) begin
            pipe_v_d[k] = pipe_v_q[k-1];
            pipe_e_d[k] = pipe_e_q[k-1];
        end
        ready_mask_d = {{(MW-1){1'b0}}, pipe_v_d[FU_LATENCY-1]}
                       << (MASK_BASE + int'(pipe_e_d[FU_LATENCY-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
            ready_mask_q  <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                older_q[i] <= '0;
            end
            for (int k = 0; k < FU_LATENCY; k++) begin
                pipe_v_q[k] <= 1'b0;
                pipe_e_q[k] <= '0;
            end
        end else begin
            alloc_q      <= alloc_d;
            older_q      <= older_d;
            pipe_v_q     <= pipe_v_d;
            pipe_e_q     <= pipe_e_d;
            ready_mask_q <= ready_mask_d;
            if (grant_valid) begin
                issue_valid_q <= 1'b1;
                issue_entry_q <= grant;
            end else if (fu_ready) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_entry  = issue_entry_q;
    assign retire_valid = pipe_v_q[FU_LATENCY-1];
    assign retire_entry = pipe_e_q[FU_LATENCY-1];
    assign ready_mask   = ready_mask_q;

endmodule

// File: tb/tb_select_issue.sv
// Bench for select_issue: directed vectors and sequences for age order, issue hold and latency,
// then randomized tracker traffic against an allocation-order reference model.
module tb_select_issue;
    localparam int RS  = 8;
    localparam int NF  = 4;
    localparam int FID = 1;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic [2:0]  disp_entry;
    logic [7:0]  reqs;
    logic [2:0]  grant;
    logic        grant_valid;
    logic        issue_valid;
    logic [2:0]  issue_entry;
    logic        fu_ready;
    logic [31:0] ready_mask;
    logic [2:0]  retire_entry;
    logic        retire_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] reqs;
        logic       fu;
        logic       dv;
        logic [2:0] de;
        logic       gv;
        logic [2:0] g;
        logic       iv;
        logic [2:0] ie;
        logic       rv;
        logic [2:0] re;
    } vec_t;

    vec_t tbl [14];
    int   t5Req  [8] = '{'h4A, 'h42, 'h02, 0, 0, 0, 0, 0};
    int   t5Grant[3] = '{3, 6, 1};

    int   st [RS];
    int   ageQ [$];
    int   freeList [$];
    bit   mIv;
    int   mIe;
    int   sched [256];

    select_issue #(.RS_ENTRIES(RS), .NUM_FUS(NF), .FU_ID(FID), .FU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_entry(disp_entry), .reqs(reqs),
        .grant(grant), .grant_valid(grant_valid), .issue_valid(issue_valid),
        .issue_entry(issue_entry), .fu_ready(fu_ready), .ready_mask(ready_mask),
        .retire_entry(retire_entry), .retire_valid(retire_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int r, int fu, int dv, int de, int gv, int g,
                                int iv, int ie, int rv, int re);
        vec_t v;
        v.reqs = 8'(r);  v.fu = 1'(fu); v.dv = 1'(dv); v.de = 3'(de);
        v.gv   = 1'(gv); v.g  = 3'(g);  v.iv = 1'(iv); v.ie = 3'(ie);
        v.rv   = 1'(rv); v.re = 3'(re);
        return v;
    endfunction

    function automatic logic [31:0] expMask(bit v, int e);
        return v ? (32'h1 << (FID * RS + e)) : 32'h0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later, well before the next rising edge.
    task automatic applyStimulus(input int r, input int rq, input int fu, input int dv, input int de);
        @(negedge clk);
        rst        = 1'(r);
        reqs       = 8'(rq);
        fu_ready   = 1'(fu);
        disp_valid = 1'(dv);
        disp_entry = 3'(de);
        #2;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic checkCompletion(input string tag, input bit v, input int e);
        checkOutput({tag, "_rv"}, 32'(retire_valid), 32'(v));
        checkOutput({tag, "_re"}, 32'(retire_entry), v ? 32'(e) : 32'h0);
        checkOutput({tag, "_mask"}, ready_mask, expMask(v, e));
    endtask

    initial begin
        rst = 1'b1; reqs = '0; fu_ready = 1'b0; disp_valid = 1'b0; disp_entry = '0;

        doReset();
        checkOutput("rst_gv", 32'(grant_valid), 0);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_iv", 32'(issue_valid), 0);
        checkOutput("rst_ie", 32'(issue_entry), 0);
        checkCompletion("rst", 0, 0);

        tbl[0]  = mk('hFF, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk('h00, 1, 1, 5, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk('h00, 1, 1, 2, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk('h00, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk('hA4, 1, 0, 0, 1, 5, 0, 0, 1, 0);
        tbl[5]  = mk('h84, 1, 0, 0, 1, 2, 1, 5, 0, 0);
        tbl[6]  = mk('h08, 1, 0, 0, 1, 3, 1, 2, 0, 0);
        tbl[7]  = mk('h01, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        tbl[8]  = mk('h01, 0, 0, 0, 0, 0, 1, 3, 1, 5);
        tbl[9]  = mk('h01, 0, 0, 0, 0, 0, 1, 3, 1, 2);
        tbl[10] = mk('h01, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        tbl[11] = mk('h01, 1, 0, 0, 1, 0, 1, 3, 0, 0);
        tbl[12] = mk('h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[13] = mk('h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, int'(tbl[i].reqs), int'(tbl[i].fu), int'(tbl[i].dv), int'(tbl[i].de));
            checkOutput($sformatf("vec%0d_gv", i), 32'(grant_valid), 32'(tbl[i].gv));
            checkOutput($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            checkOutput($sformatf("vec%0d_iv", i), 32'(issue_valid), 32'(tbl[i].iv));
            checkOutput($sformatf("vec%0d_ie", i), 32'(issue_entry), 32'(tbl[i].ie));
            checkCompletion($sformatf("vec%0d", i), tbl[i].rv, int'(tbl[i].re));
        end

        // Latency: entry 4 handed off at T completes exactly at T+LAT on ready_mask bit 12.
        doReset();
        applyStimulus(0, 'h10, 1, 0, 0);
        checkOutput("t4_gv", 32'(grant_valid), 1);
        checkOutput("t4_grant", 32'(grant), 4);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t4_iv", 32'(issue_valid), 1);
        checkOutput("t4_ie", 32'(issue_entry), 4);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkCompletion($sformatf("t4_T+%0d", k), k == LAT, 4);
            if (k == LAT) checkOutput("t4_bit12", ready_mask, 32'h0000_1000);
        end

        doReset();
        applyStimulus(0, 0, 1, 1, 3);
        applyStimulus(0, 0, 1, 1, 6);
        applyStimulus(0, 0, 1, 1, 1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, t5Req[k], 1, 0, 0);
            if (k < 3) begin
                checkOutput($sformatf("t5_gv%0d", k), 32'(grant_valid), 1);
                checkOutput($sformatf("t5_grant%0d", k), 32'(grant), 32'(t5Grant[k]));
            end
            checkCompletion($sformatf("t5_c%0d", k), (k >= 4 && k <= 6),
                            (k >= 4 && k <= 6) ? t5Grant[k-4] : 0);
        end

        // Reset two cycles after handoff must swallow the completion and forget the age order.
        doReset();
        applyStimulus(0, 0, 1, 1, 6);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 'h42, 1, 0, 0);
        checkOutput("t6_grant_old", 32'(grant), 6);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t6_iv", 32'(issue_valid), 1);
        checkOutput("t6_ie", 32'(issue_entry), 6);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkCompletion($sformatf("t6_quiet%0d", k), 0, 0);
            checkOutput($sformatf("t6_iv%0d", k), 32'(issue_valid), 0);
        end
        applyStimulus(0, 'h42, 1, 0, 0);
        checkOutput("t6_gv_new", 32'(grant_valid), 1);
        checkOutput("t6_grant_new", 32'(grant), 1);

        doReset();
        for (int e = 0; e < RS; e++) st[e] = 0;
        ageQ.delete();
        mIv = 1'b0;
        mIe = 0;
        for (int k = 0; k < 256; k++) sched[k] = -1;
        for (int c = 0; c < 400; c++) begin
            logic [7:0] rq;
            bit         dV, fu, expGv, got;
            int         dE, expG, expRe;
            rq = '0;
            freeList.delete();
            for (int e = 0; e < RS; e++) begin
                if (st[e] == 2) rq[e] = 1'b1;
                if (st[e] == 0) freeList.push_back(e);
            end
            dV = 1'b0;
            dE = 0;
            if (freeList.size() > 0 && $urandom_range(0, 1) == 1) begin
                dV = 1'b1;
                dE = freeList[$urandom_range(0, freeList.size() - 1)];
            end
            fu = ($urandom_range(0, 3) != 0);
            applyStimulus(0, int'(rq), int'(fu), int'(dV), dE);

            expRe = sched[c % 256];
            sched[c % 256] = -1;
            expGv = (rq != 0) && (!mIv || fu);
            expG  = 0;
            got   = 1'b0;
            for (int k = 0; k < ageQ.size(); k++) begin
                if (!got && rq[ageQ[k]]) begin
                    got  = 1'b1;
                    expG = ageQ[k];
                end
            end
            checkOutput($sformatf("rnd%0d_gv", c), 32'(grant_valid), 32'(expGv));
            checkOutput($sformatf("rnd%0d_grant", c), 32'(grant), 32'(expG));
            checkOutput($sformatf("rnd%0d_iv", c), 32'(issue_valid), 32'(mIv));
            checkOutput($sformatf("rnd%0d_ie", c), 32'(issue_entry), 32'(mIe));
            checkCompletion($sformatf("rnd%0d", c), expRe >= 0, (expRe >= 0) ? expRe : 0);
            if (dV) checkOutput($sformatf("rnd%0d_disp_free", c),
                                32'(retire_valid && (int'(retire_entry) == dE)), 0);

            if (expRe >= 0) begin
                st[expRe] = 0;
                for (int k = ageQ.size() - 1; k >= 0; k--) begin
                    if (ageQ[k] == expRe) ageQ.delete(k);
                end
            end
            if (mIv && fu) sched[(c + LAT) % 256] = mIe;
            if (expGv) begin
                st[expG] = 3;
                mIv = 1'b1;
                mIe = expG;
            end else if (fu) begin
                mIv = 1'b0;
            end
            for (int e = 0; e < RS; e++) begin
                if (st[e] == 1 && $urandom_range(0, 1) == 1) st[e] = 2;
            end
            if (dV) begin
                st[dE] = 1;
                ageQ.push_back(dE);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
